// File: rtl/result_writer_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | result_writer_pkg : shared types and sizes for result_writer      |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package result_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int NUM_RESULTS = 8;
    localparam int AVM_DATA_W  = 64;
    localparam int IDX_W       = $clog2(NUM_RESULTS);

endpackage
`default_nettype wire

// File: rtl/result_writer.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | result_writer : snapshots 8 MAC results, writes them over Avalon  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module result_writer
    import result_writer_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DATA_WIDTH*3-1:0]   c_in [0:NUM_RESULTS-1],
    output logic                      done,
    output logic [31:0]               avm_address,
    output logic                      avm_write,
    output logic [AVM_DATA_W-1:0]     avm_writedata,
    input  logic                      avm_waitrequest,
    output logic [1:0]                dbg_state,
    output logic [IDX_W-1:0]          dbg_idx
);

    localparam int RES_W = DATA_WIDTH * 3;

    state_t              r_state;
    state_t              w_next_state;
    logic [IDX_W-1:0]    r_idx;
    logic [RES_W-1:0]    r_snapshot [0:NUM_RESULTS-1];
    logic                w_accept;
    logic                w_last;

    assign w_accept = (r_state == ST_WRITE) && !avm_waitrequest;
    assign w_last   = (r_idx == IDX_W'(NUM_RESULTS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next_state = ST_CAPTURE;
            ST_CAPTURE: w_next_state = ST_WRITE;
            ST_WRITE:   if (w_accept && w_last) w_next_state = ST_DONE;
            ST_DONE:    if (!start) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Snapshot decouples the bus sequence from later activity on c_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            for (int i = 0; i < NUM_RESULTS; i++) begin
                r_snapshot[i] <= '0;
            end
        end else if (r_state == ST_CAPTURE) begin
            r_idx <= '0;
            for (int i = 0; i < NUM_RESULTS; i++) begin
                r_snapshot[i] <= c_in[i];
            end
        end else if (w_accept && !w_last) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    always_comb begin
        avm_write     = 1'b0;
        avm_address   = '0;
        avm_writedata = '0;
        done          = (r_state == ST_DONE);
        if (r_state == ST_WRITE) begin
            avm_write     = 1'b1;
            avm_address   = BASE_ADDR + 32'(r_idx);
            avm_writedata = AVM_DATA_W'(r_snapshot[r_idx]);
        end
    end

    assign dbg_state = r_state;
    assign dbg_idx   = r_idx;

endmodule
`default_nettype wire
